axi_addr_window_guard: RTL and testbench

Parametrised address-window guard for one NOC slave port. It sits between the interconnect-side AXI bus and a slave's native AXI port. It forwards transactions whose start address falls inside the slave's window. Out-of-range transactions are terminated locally with DECERR responses: write data is drained and read beats are generated, so the bus never hangs. It also keeps error statistics, replacing the fixed-window, assertion-only slave checks of the previous generation.

---
 rtl/axi_addr_window_guard_pkg.sv | 30 +++
 rtl/axi_addr_window_guard_rd_err.sv | 36 +++
 rtl/axi_addr_window_guard.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_addr_window_guard.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_addr_window_guard_pkg.sv
// Shared types and helpers for the AXI address-window guard.
// Response codes, FSM state enums and the window-membership check.
package axi_addr_window_guard_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_PASS,
    W_DRAIN,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PASS,
    R_ERR
  } rd_state_e;

  // size must be a power of two and base aligned to it
  function automatic logic in_window(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] size
  );
    return (addr & ~(size - 64'd1)) == base;
  endfunction

endpackage

// File: rtl/axi_addr_window_guard_rd_err.sv
// Read-error beat generator: holds the rejected ID and counts out
// arlen+1 DECERR beats, stepping only on accepted beats.
// Ports: start/id_in/len_in load, active/rready step, rid/rlast/done out.
module axi_addr_window_guard_rd_err #(
  parameter int ID_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ID_W-1:0] id_in,
  input  logic [7:0]      len_in,
  input  logic            active,
  input  logic            rready,
  output logic [ID_W-1:0] rid,
  output logic            rlast,
  output logic            done
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rid <= '0;
    end else if (start) begin
      cnt <= len_in;
      rid <= id_in;
    end else if (active && rready && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign rlast = active && (cnt == 8'd0);
  assign done  = rlast && rready;

endmodule

// File: rtl/axi_addr_window_guard.sv
// Address-window guard for one slave port: forwards in-window bursts,
// answers the rest locally with DECERR and tracks rejection stats.
// Ports: s_* upstream AXI, m_* downstream AXI, err_* statistics.
module axi_addr_window_guard
  import axi_addr_window_guard_pkg::*;
#(
  parameter int              ID_W      = 6,
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_C000,
  parameter int              WIN_SIZE  = 4096,
  parameter int              CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [CNT_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                err_pulse
);

  wr_state_e       w_state, w_next;
  rd_state_e       r_state, r_next;
  logic [ID_W-1:0] aw_id_q;
  logic            aw_in, ar_in;
  logic            aw_rej, ar_rej;
  logic [ID_W-1:0] e_rid;
  logic            e_rlast, e_done;

  assign aw_in = in_window(64'(s_awaddr), 64'(BASE_ADDR),
                           64'(WIN_SIZE));
  assign ar_in = in_window(64'(s_araddr), 64'(BASE_ADDR),
                           64'(WIN_SIZE));

  assign aw_rej = !rst && w_state == W_IDLE
                  && s_awvalid && !aw_in;
  assign ar_rej = !rst && r_state == R_IDLE
                  && s_arvalid && !ar_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      aw_id_q <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (aw_rej) aw_id_q <= s_awid;
    end
  end

  always_comb begin
    w_next    = w_state;
    m_awvalid = 1'b0;
    s_awready = 1'b0;
    m_awid    = '0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_wvalid  = 1'b0;
    s_wready  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    s_bvalid  = 1'b0;
    s_bid     = '0;
    s_bresp   = RESP_OKAY;
    m_bready  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (s_awvalid && aw_in) begin
          m_awvalid = 1'b1;
          s_awready = m_awready;
          m_awid    = s_awid;
          m_awaddr  = s_awaddr;
          m_awlen   = s_awlen;
          if (m_awready) w_next = W_PASS;
        end else if (s_awvalid) begin
          s_awready = 1'b1;
          w_next    = W_DRAIN;
        end
      end
      W_PASS: begin
        m_wvalid = s_wvalid;
        s_wready = m_wready;
        m_wdata  = s_wdata;
        m_wstrb  = s_wstrb;
        m_wlast  = s_wlast;
        s_bvalid = m_bvalid;
        s_bid    = m_bid;
        s_bresp  = m_bresp;
        m_bready = s_bready;
        if (m_bvalid && s_bready) w_next = W_IDLE;
      end
      W_DRAIN: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) w_next = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        s_bid    = aw_id_q;
        s_bresp  = RESP_DECERR;
        if (s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
    // handshakes stay quiet while reset is held
    if (rst) begin
      m_awvalid = 1'b0;
      s_awready = 1'b0;
      m_wvalid  = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      m_bready  = 1'b0;
    end
  end

  always_comb begin
    r_next    = r_state;
    m_arvalid = 1'b0;
    s_arready = 1'b0;
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    s_rvalid  = 1'b0;
    s_rid     = '0;
    s_rdata   = '0;
    s_rresp   = RESP_OKAY;
    s_rlast   = 1'b0;
    m_rready  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (s_arvalid && ar_in) begin
          m_arvalid = 1'b1;
          s_arready = m_arready;
          m_arid    = s_arid;
          m_araddr  = s_araddr;
          m_arlen   = s_arlen;
          if (m_arready) r_next = R_PASS;
        end else if (s_arvalid) begin
          s_arready = 1'b1;
          r_next    = R_ERR;
        end
      end
      R_PASS: begin
        s_rvalid = m_rvalid;
        s_rid    = m_rid;
        s_rdata  = m_rdata;
        s_rresp  = m_rresp;
        s_rlast  = m_rlast;
        m_rready = s_rready;
        if (m_rvalid && s_rready && m_rlast) r_next = R_IDLE;
      end
      R_ERR: begin
        s_rvalid = 1'b1;
        s_rid    = e_rid;
        s_rresp  = RESP_DECERR;
        s_rlast  = e_rlast;
        if (e_done) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
    if (rst) begin
      m_arvalid = 1'b0;
      s_arready = 1'b0;
      s_rvalid  = 1'b0;
      m_rready  = 1'b0;
    end
  end

  axi_addr_window_guard_rd_err #(
    .ID_W(ID_W)
  ) u_rd_err (
    .clk   (clk),
    .rst   (rst),
    .start (ar_rej),
    .id_in (s_arid),
    .len_in(s_arlen),
    .active(r_state == R_ERR),
    .rready(s_rready),
    .rid   (e_rid),
    .rlast (e_rlast),
    .done  (e_done)
  );

  logic [1:0]     n_rej;
  logic [CNT_W:0] cnt_sum;

  assign n_rej   = {1'b0, aw_rej} + {1'b0, ar_rej};
  assign cnt_sum = {1'b0, err_count} + (CNT_W + 1)'(n_rej);

  // AR wins err_addr when both channels reject together
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
      err_addr  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= aw_rej || ar_rej;
      if (cnt_sum[CNT_W]) err_count <= '1;
      else err_count <= cnt_sum[CNT_W-1:0];
      if (ar_rej) err_addr <= s_araddr;
      else if (aw_rej) err_addr <= s_awaddr;
    end
  end

endmodule

// File: tb/tb_axi_addr_window_guard.sv
// Self-checking bench for axi_addr_window_guard (CNT_W = 4).
// Vector table plus hand sequences; responses checked via a scoreboard.
module tb_axi_addr_window_guard;

  logic        clk = 0;
  logic        rst;
  logic [5:0]  s_awid, s_arid, s_bid, s_rid;
  logic [31:0] s_awaddr, s_araddr;
  logic [7:0]  s_awlen, s_arlen;
  logic        s_awvalid, s_awready, s_arvalid, s_arready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast, s_wvalid, s_wready;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_rlast, s_rvalid, s_rready;
  logic [5:0]  m_awid, m_arid, m_bid, m_rid;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [7:0]  m_awlen, m_arlen;
  logic        m_awvalid, m_awready, m_arvalid, m_arready;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_rlast, m_rvalid, m_rready;
  logic [3:0]  err_count;
  logic [31:0] err_addr;
  logic        err_pulse;

  axi_addr_window_guard #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .err_count(err_count), .err_addr(err_addr),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [5:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    bit          toggle;
    bit          exp_pass;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
    int         beats;
    bit         pass;
  } exp_t;

  vec_t        vt[7];
  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_exp = 0;
  logic [31:0] err_addr_exp = '0;
  logic [5:0]  cap_awid, cap_arid;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic note_rej(input int n, input logic [31:0] a);
    err_exp = (err_exp + n > 15) ? 15 : err_exp + n;
    err_addr_exp = a;
  endtask

  task automatic pop_exp(output exp_t e);
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: got 0 want 1 entries");
      e = '{id: '0, resp: '0, beats: 1, pass: 0};
    end else begin
      e = sbq.pop_front();
    end
  endtask

  task automatic stats_after(input bit rej);
    #1;
    check("err_pulse", err_pulse, rej);
    check("err_count", err_count, err_exp);
    check("err_addr", err_addr, err_addr_exp);
  endtask

  task automatic aw_phase(input logic [5:0] id,
                          input logic [31:0] a,
                          input logic [7:0] len, input bit pass);
    s_awvalid = 1; s_awid = id; s_awaddr = a; s_awlen = len;
    #1;
    check("s_awready", s_awready, 1);
    check("m_awvalid", m_awvalid, pass);
    if (pass) begin
      check("m_awaddr", m_awaddr, a);
      check("m_awlen", m_awlen, len);
      cap_awid = m_awid;
    end
    @(posedge clk); @(negedge clk);
    s_awvalid = 0; s_awaddr = '0;
    if (!pass) note_rej(1, a);
    stats_after(!pass);
  endtask

  task automatic ar_phase(input logic [5:0] id,
                          input logic [31:0] a,
                          input logic [7:0] len, input bit pass);
    s_arvalid = 1; s_arid = id; s_araddr = a; s_arlen = len;
    #1;
    check("s_arready", s_arready, 1);
    check("m_arvalid", m_arvalid, pass);
    if (pass) begin
      check("m_araddr", m_araddr, a);
      check("m_arlen", m_arlen, len);
      cap_arid = m_arid;
    end
    @(posedge clk); @(negedge clk);
    s_arvalid = 0; s_araddr = '0;
    if (!pass) note_rej(1, a);
    stats_after(!pass);
  endtask

  task automatic w_phase(input logic [7:0] len, input bit pass);
    int n;
    for (int b = 0; b <= int'(len); b++) begin
      s_wvalid = 1; s_wdata = 32'h5000_0000 + b;
      s_wstrb = 4'hF; s_wlast = (b == int'(len));
      n = 0;
      #1;
      while (!s_wready && n < 20) begin
        @(negedge clk); #1; n++;
      end
      check("w_wait", n, 0);
      check("m_wvalid", m_wvalid, pass);
      if (pass) begin
        check("m_wdata", m_wdata, 32'h5000_0000 + b);
        check("m_wlast", m_wlast, b == int'(len));
      end
      @(posedge clk); @(negedge clk);
    end
    s_wvalid = 0; s_wlast = 0;
  endtask

  task automatic b_phase();
    exp_t e;
    int n;
    pop_exp(e);
    if (e.pass) begin
      m_bvalid = 1; m_bid = cap_awid; m_bresp = 2'b00;
    end
    s_bready = 1; n = 0;
    #1;
    while (!s_bvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("b_wait", n, 0);
    check("s_bid", s_bid, e.id);
    check("s_bresp", s_bresp, e.resp);
    if (e.pass) check("m_bready", m_bready, 1);
    @(posedge clk); @(negedge clk);
    m_bvalid = 0; s_bready = 0;
    #1 check("b_idle", s_bvalid, 0);
  endtask

  // abort_at >= 0 stops before that beat index, leaving a burst open
  task automatic r_phase(input bit toggle, input int abort_at);
    exp_t e;
    int beat, n;
    logic [31:0] dexp;
    pop_exp(e);
    beat = 0; n = 0;
    while (beat < e.beats && n < 200) begin
      if (abort_at >= 0 && beat == abort_at) return;
      s_rready = toggle ? n[0] : 1'b1;
      dexp = e.pass ? 32'hA000_0000 + beat : 32'h0;
      if (e.pass) begin
        m_rvalid = 1; m_rid = cap_arid; m_rdata = dexp;
        m_rresp = 2'b00; m_rlast = (beat == e.beats - 1);
      end
      #1;
      check("s_rvalid", s_rvalid, 1);
      check("s_rdata", s_rdata, dexp);
      check("s_rresp", s_rresp, e.resp);
      check("s_rid", s_rid, e.id);
      check("s_rlast", s_rlast, beat == e.beats - 1);
      if (e.pass) check("m_rready", m_rready, s_rready);
      if (s_rvalid && s_rready) beat++;
      n++;
      @(posedge clk); @(negedge clk);
    end
    m_rvalid = 0; m_rlast = 0; s_rready = 0;
    check("r_beats", beat, e.beats);
    #1 check("r_idle", s_rvalid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awvalid = 0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 0; s_wvalid = 0;
    s_bready = 0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arvalid = 0;
    s_rready = 0;
    m_awready = 1; m_wready = 1; m_arready = 1;
    m_bid = '0; m_bresp = '0; m_bvalid = 0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
    m_rvalid = 0;
    cap_awid = '0; cap_arid = '0;

    vt[0] = '{1, 6'h05, 32'h0000_C010, 8'd3, 0, 1, 2'b00};
    vt[1] = '{1, 6'h2A, 32'h0000_D000, 8'd3, 0, 0, 2'b11};
    vt[2] = '{0, 6'h11, 32'h0001_0000, 8'd7, 1, 0, 2'b11};
    vt[3] = '{0, 6'h03, 32'h0000_C0FC, 8'd1, 1, 1, 2'b00};
    vt[4] = '{1, 6'h07, 32'h0000_BFFC, 8'd0, 0, 0, 2'b11};
    vt[5] = '{0, 6'h1F, 32'h0000_CFFC, 8'd0, 0, 1, 2'b00};
    vt[6] = '{1, 6'h3F, 32'hFFFF_C000, 8'd1, 0, 0, 2'b11};

    repeat (3) @(negedge clk);
    #1;
    check("rst_s_rvalid", s_rvalid, 0);
    check("rst_s_bvalid", s_bvalid, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_err_count", err_count, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_s_awready", s_awready, 0);
    check("rst_s_wready", s_wready, 0);
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_m_arvalid", m_arvalid, 0);
    @(negedge clk);

    foreach (vt[i]) begin
      sbq.push_back('{id: vt[i].id, resp: vt[i].exp_resp,
                      beats: int'(vt[i].len) + 1,
                      pass: vt[i].exp_pass});
      if (vt[i].wr) begin
        aw_phase(vt[i].id, vt[i].addr, vt[i].len, vt[i].exp_pass);
        w_phase(vt[i].len, vt[i].exp_pass);
        b_phase();
      end else begin
        ar_phase(vt[i].id, vt[i].addr, vt[i].len, vt[i].exp_pass);
        r_phase(vt[i].toggle, -1);
      end
      @(negedge clk);
      #1 check("pulse_clear", err_pulse, 0);
    end

    // simultaneous AW and AR rejection
    @(negedge clk);
    s_awvalid = 1; s_awid = 6'h0A; s_awaddr = 32'h0; s_awlen = 0;
    s_arvalid = 1; s_arid = 6'h0B; s_araddr = 32'hFFFF_F000;
    s_arlen = 0;
    #1;
    check("dual_awready", s_awready, 1);
    check("dual_arready", s_arready, 1);
    check("dual_m_awvalid", m_awvalid, 0);
    check("dual_m_arvalid", m_arvalid, 0);
    @(posedge clk); @(negedge clk);
    s_awvalid = 0; s_arvalid = 0;
    note_rej(2, 32'hFFFF_F000);
    stats_after(1);
    sbq.push_back('{id: 6'h0A, resp: 2'b11, beats: 1, pass: 0});
    sbq.push_back('{id: 6'h0B, resp: 2'b11, beats: 1, pass: 0});
    w_phase(8'd0, 0);
    #1 check("dual_pulse_one", err_pulse, 0);
    @(negedge clk);
    b_phase();
    @(negedge clk);
    r_phase(0, -1);

    // reset on beat 3 of an 8-beat error burst
    @(negedge clk);
    sbq.push_back('{id: 6'h33, resp: 2'b11, beats: 8, pass: 0});
    ar_phase(6'h33, 32'h0003_0000, 8'd7, 0);
    r_phase(0, 2);
    rst = 1; s_rready = 0;
    @(posedge clk); @(negedge clk);
    rst = 0;
    err_exp = 0; err_addr_exp = '0;
    #1;
    check("abort_s_rvalid", s_rvalid, 0);
    check("abort_s_bvalid", s_bvalid, 0);
    check("abort_s_wready", s_wready, 0);
    check("abort_m_arvalid", m_arvalid, 0);
    check("abort_m_rready", m_rready, 0);
    check("abort_err_count", err_count, 0);
    @(negedge clk);
    sbq.push_back('{id: 6'h09, resp: 2'b00, beats: 3, pass: 1});
    ar_phase(6'h09, 32'h0000_C200, 8'd2, 1);
    r_phase(0, -1);

    // saturation: 2^4 + 5 rejections
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      sbq.push_back('{id: 6'(i), resp: 2'b11, beats: 1, pass: 0});
      ar_phase(6'(i), 32'h0002_0000 + 32'(i * 4096), 8'd0, 0);
      r_phase(0, -1);
    end
    #1 check("sat_count", err_count, 4'hF);
    check("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
